// File: rtl/pwm_core.sv
// pwm_core: prescaled counter/compare PWM engine with shadowed period/duty/prescale.
// Optional complementary output with dead time: define PWM_DEADTIME_EN.
module pwm_core #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16,
    parameter int DT_W  = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [31:0]      cfg_ctrl,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_update,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]  cfg_deadtime,
    output logic             pwm_out_n,
`endif
    output logic             pwm_out,
    output logic             period_tick,
    output logic             update_pending,
    output logic [CNT_W-1:0] cnt_value
);

    logic             en_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sh_per_q, sh_per_d;
    logic [CNT_W-1:0] sh_duty_q, sh_duty_d;
    logic [PRE_W-1:0] sh_pre_q, sh_pre_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             pwm_q, pwm_d;

    logic en, inv, rise, run, tick, wrap, load, lvl;
    logic unused_ctrl;

    assign en          = cfg_ctrl[0];
    assign inv         = cfg_ctrl[1];
    assign unused_ctrl = ^cfg_ctrl[31:2];

    // run needs a full enabled cycle so the rise cycle never compares stale shadows
    assign rise = en & ~en_q;
    assign run  = en & en_q;
    assign tick = (pre_q == sh_pre_q);
    assign wrap = run & tick & (cnt_q == sh_per_q);
    assign load = rise | (wrap & (pend_q | cfg_update));
    assign lvl  = run ? ((cnt_q < sh_duty_q) ^ inv) : inv;

    always_comb begin
        pre_d     = '0;
        cnt_d     = '0;
        sh_per_d  = sh_per_q;
        sh_duty_d = sh_duty_q;
        sh_pre_d  = sh_pre_q;
        pend_d    = pend_q | cfg_update;
        tick_d    = wrap;
        if (run) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            cnt_d = cnt_q;
            if (tick) begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            end
        end
        if (load) begin
            sh_per_d  = cfg_period;
            sh_duty_d = cfg_duty;
            sh_pre_d  = cfg_prescale;
            pend_d    = 1'b0;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic            lvl_q;
    logic [DT_W-1:0] dt_q, dt_d;
    logic            pwmn_q, pwmn_d;

    // any level change (re)starts the dead band; both outputs stay low while it runs
    always_comb begin
        dt_d = '0;
        if (lvl != lvl_q) begin
            dt_d = cfg_deadtime;
        end else if (dt_q != '0) begin
            dt_d = dt_q - DT_W'(1);
        end
        pwm_d  = lvl & (dt_d == '0);
        pwmn_d = run & ~lvl & (dt_d == '0);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            lvl_q  <= 1'b0;
            dt_q   <= '0;
            pwmn_q <= 1'b0;
        end else begin
            lvl_q  <= lvl;
            dt_q   <= dt_d;
            pwmn_q <= pwmn_d;
        end
    end

    assign pwm_out_n = pwmn_q;
`else
    logic [DT_W-1:0] unused_dt;

    assign unused_dt = '0;
    assign pwm_d     = lvl;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            en_q      <= 1'b0;
            pre_q     <= '0;
            cnt_q     <= '0;
            sh_per_q  <= '0;
            sh_duty_q <= '0;
            sh_pre_q  <= '0;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            en_q      <= en;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            sh_per_q  <= sh_per_d;
            sh_duty_q <= sh_duty_d;
            sh_pre_q  <= sh_pre_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out        = pwm_q;
    assign period_tick    = tick_q;
    assign update_pending = pend_q;
    assign cnt_value      = cnt_q;

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed + random stimulus checked against an elapsed-time model.
// Define PWM_DEADTIME_EN to also exercise the complementary dead-time output.
module tb_pwm_core;

    localparam int CNT_W = 32;
    localparam int PRE_W = 16;
    localparam int DT_W  = 8;

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic [31:0]      cfg_ctrl = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_duty = '0;
    logic [PRE_W-1:0] cfg_prescale = '0;
    logic             cfg_update = 1'b0;
    logic             pwm_out;
    logic             period_tick;
    logic             update_pending;
    logic [CNT_W-1:0] cnt_value;
`ifdef PWM_DEADTIME_EN
    logic [DT_W-1:0]  cfg_deadtime = '0;
    logic             pwm_out_n;
`endif

    pwm_core #(.CNT_W(CNT_W), .PRE_W(PRE_W), .DT_W(DT_W)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cfg_ctrl      (cfg_ctrl),
        .cfg_period    (cfg_period),
        .cfg_duty      (cfg_duty),
        .cfg_prescale  (cfg_prescale),
        .cfg_update    (cfg_update),
`ifdef PWM_DEADTIME_EN
        .cfg_deadtime  (cfg_deadtime),
        .pwm_out_n     (pwm_out_n),
`endif
        .pwm_out       (pwm_out),
        .period_tick   (period_tick),
        .update_pending(update_pending),
        .cnt_value     (cnt_value)
    );

    always #5 ACLK = ~ACLK;

    int n_assert = 0;
    int n_fail = 0;

    // model: clocks elapsed inside the current period plus active settings
    bit     m_hist;
    longint m_e, m_P, m_D, m_S;
    bit     m_pend, m_tick, m_pwm, m_pwmn, m_lvl;
    int     m_dt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = 0; m_e = 0; m_P = 0; m_D = 0; m_S = 0;
        m_pend = 0; m_tick = 0; m_pwm = 0; m_pwmn = 0; m_lvl = 0; m_dt = 0;
    endtask

    task automatic model_load();
        m_P = longint'(cfg_period);
        m_D = longint'(cfg_duty);
        m_S = longint'(cfg_prescale);
        m_pend = 0;
    endtask

    task automatic model_edge();
        bit en, inv, run, lvl;
        if (ARESET) begin
            model_reset();
            return;
        end
        en  = cfg_ctrl[0];
        inv = cfg_ctrl[1];
        run = en && m_hist;
        lvl = run ? ((m_e / (m_S + 1) < m_D) ^ inv) : inv;
        if (!run) begin
            m_e = 0;
            m_tick = 0;
            if (en) model_load();
            else m_pend = m_pend | cfg_update;
        end else begin
            m_e++;
            m_tick = (m_e == (m_P + 1) * (m_S + 1));
            if (m_tick) m_e = 0;
            if (m_tick && (m_pend || cfg_update)) model_load();
            else m_pend = m_pend | cfg_update;
        end
        m_hist = en;
`ifdef PWM_DEADTIME_EN
        if (lvl != m_lvl) m_dt = int'(cfg_deadtime);
        else if (m_dt > 0) m_dt--;
        m_lvl  = lvl;
        m_pwm  = lvl && (m_dt == 0);
        m_pwmn = run && !lvl && (m_dt == 0);
`else
        m_pwm = lvl;
`endif
    endtask

    task automatic check_all();
        chk("pwm_out", 64'(pwm_out), 64'(m_pwm));
        chk("period_tick", 64'(period_tick), 64'(m_tick));
        chk("update_pending", 64'(update_pending), 64'(m_pend));
        chk("cnt_value", 64'(cnt_value), 64'(m_e / (m_S + 1)));
`ifdef PWM_DEADTIME_EN
        chk("pwm_out_n", 64'(pwm_out_n), 64'(m_pwmn));
`endif
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic upd();
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
    endtask

    task automatic run_count(input int n, output int hi, output int tk, output int hin);
        hi = 0; tk = 0; hin = 0;
        repeat (n) begin
            step();
            hi += int'(pwm_out);
            tk += int'(period_tick);
`ifdef PWM_DEADTIME_EN
            hin += int'(pwm_out_n);
`endif
        end
    endtask

    task automatic wait_tick(input int limit);
        int k = 0;
        do begin
            step();
            k++;
        end while (!period_tick && k < limit);
        chk("wait_tick", 64'(period_tick), 64'(1));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pwm"}, 64'(pwm_out), 64'(0));
        chk({tag, "_tick"}, 64'(period_tick), 64'(0));
        chk({tag, "_pend"}, 64'(update_pending), 64'(0));
        chk({tag, "_cnt"}, 64'(cnt_value), 64'(0));
`ifdef PWM_DEADTIME_EN
        chk({tag, "_pwmn"}, 64'(pwm_out_n), 64'(0));
`endif
    endtask

    int hi, tk, hin;

    initial begin
        model_reset();
        #1;
        chk_reset_outs("rst");

        // basic duty
        cfg_period = 9; cfg_duty = 3; cfg_prescale = 0; cfg_ctrl = 1;
        steps(2);
        ARESET = 1'b0;
        steps(2);
        run_count(10, hi, tk, hin);
        chk("basic_hi", 64'(hi), 64'(3));
        chk("basic_tick", 64'(tk), 64'(1));
        run_count(20, hi, tk, hin);
        chk("basic_hi20", 64'(hi), 64'(6));
        chk("basic_tick20", 64'(tk), 64'(2));

        // boundaries
        cfg_duty = 0; upd(); steps(12);
        run_count(10, hi, tk, hin);
        chk("duty0_hi", 64'(hi), 64'(0));
        cfg_duty = 10; upd(); steps(12);
        run_count(10, hi, tk, hin);
        chk("dutyover_hi", 64'(hi), 64'(10));
        cfg_period = 0; cfg_duty = 1; upd(); steps(12);
        run_count(10, hi, tk, hin);
        chk("per0_hi", 64'(hi), 64'(10));
        chk("per0_tick", 64'(tk), 64'(10));
        cfg_ctrl = 3; steps(2);
        run_count(10, hi, tk, hin);
        chk("per0_inv_hi", 64'(hi), 64'(0));
        chk("per0_inv_tick", 64'(tk), 64'(10));
        cfg_duty = 0; upd(); steps(3);
        run_count(10, hi, tk, hin);
        chk("duty0_inv_hi", 64'(hi), 64'(10));

        // prescale
        cfg_ctrl = 1; cfg_period = 4; cfg_duty = 2; cfg_prescale = 3;
        upd(); steps(25);
        run_count(20, hi, tk, hin);
        chk("pre_hi", 64'(hi), 64'(8));
        chk("pre_tick", 64'(tk), 64'(1));

        // shadow update mid-period
        cfg_period = 9; cfg_duty = 3; cfg_prescale = 0;
        upd(); wait_tick(40); wait_tick(15);
        steps(3);
        cfg_duty = 7; upd();
        chk("pend_set", 64'(update_pending), 64'(1));
        wait_tick(15);
        chk("pend_clr", 64'(update_pending), 64'(0));
        run_count(10, hi, tk, hin);
        chk("upd_hi", 64'(hi), 64'(7));

        // update coincident with period end
        steps(9);
        chk("cnt_nine", 64'(cnt_value), 64'(9));
        cfg_duty = 2; upd();
        chk("coinc_tick", 64'(period_tick), 64'(1));
        chk("coinc_pend", 64'(update_pending), 64'(0));
        run_count(10, hi, tk, hin);
        chk("coinc_hi", 64'(hi), 64'(2));

        // disable / re-enable
        steps(4);
        cfg_ctrl = 0; step();
        chk("dis_pwm", 64'(pwm_out), 64'(0));
        chk("dis_cnt", 64'(cnt_value), 64'(0));
        cfg_ctrl = 2; step();
        chk("dis_inv_pwm", 64'(pwm_out), 64'(1));
        cfg_duty = 5; upd();
        chk("dis_pend", 64'(update_pending), 64'(1));
        steps(2);
        cfg_ctrl = 1; step();
        chk("reen_cnt", 64'(cnt_value), 64'(0));
        chk("reen_pend", 64'(update_pending), 64'(0));
        step();
        run_count(10, hi, tk, hin);
        chk("reen_hi", 64'(hi), 64'(5));

        // asynchronous reset mid-period
        steps(3);
        ARESET = 1'b1;
        #1;
        chk_reset_outs("arst");
        model_reset();
        steps(2);
        ARESET = 1'b0;
        steps(2);
        run_count(10, hi, tk, hin);
        chk("arst_hi", 64'(hi), 64'(5));

        // random
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                cfg_period   = $urandom_range(12, 0);
                cfg_duty     = $urandom_range(14, 0);
                cfg_prescale = PRE_W'($urandom_range(3, 0));
`ifdef PWM_DEADTIME_EN
                cfg_deadtime = DT_W'($urandom_range(3, 0));
`endif
            end
            cfg_update = ($urandom_range(9, 0) == 0);
            if ($urandom_range(59, 0) == 0) cfg_ctrl[0] = ~cfg_ctrl[0];
            if ($urandom_range(49, 0) == 0) cfg_ctrl[1] = ~cfg_ctrl[1];
            step();
            cfg_update = 1'b0;
        end

`ifdef PWM_DEADTIME_EN
        cfg_ctrl = 1; cfg_period = 9; cfg_duty = 5; cfg_prescale = 0;
        cfg_deadtime = 2;
        upd(); steps(30);
        run_count(10, hi, tk, hin);
        chk("dt_hi", 64'(hi), 64'(3));
        chk("dt_hin", 64'(hin), 64'(3));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
